// File: rtl/branch_pred_unit.sv
// Branch prediction and resolution unit: 2-bit BHT + direct-mapped BTB lookup
// at fetch, mispredict detection and table training at execute, and saturating
// branch/mispredict performance counters.
module branch_pred_unit #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned IDX_BITS = 6,
  localparam int unsigned TAG_BITS = XLEN - IDX_BITS - 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_fetch,
  input  logic            fetch_valid,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  output logic            branch_taken,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  input  logic            ex_actual_taken,
  input  logic [XLEN-1:0] ex_actual_target,
  output logic            branch_mispredicted,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
);

  localparam int unsigned NUM_ENT = 1 << IDX_BITS;
  localparam int unsigned CNT_W   = 32;

  // Prediction tables
  logic [1:0]          bht_q        [NUM_ENT];
  logic [1:0]          bht_d        [NUM_ENT];
  logic [NUM_ENT-1:0]  btb_valid_q, btb_valid_d;
  logic [TAG_BITS-1:0] btb_tag_q    [NUM_ENT];
  logic [TAG_BITS-1:0] btb_tag_d    [NUM_ENT];
  logic [XLEN-1:0]     btb_target_q [NUM_ENT];
  logic [XLEN-1:0]     btb_target_d [NUM_ENT];

  // Performance counters
  logic [CNT_W-1:0]    branch_count_q, branch_count_d;
  logic [CNT_W-1:0]    mispredict_count_q, mispredict_count_d;

  logic [IDX_BITS-1:0] f_idx, ex_idx;
  logic [TAG_BITS-1:0] f_tag, ex_tag;
  logic                btb_hit;
  logic                resolve;
  logic                mispredict;

  // Fetch-side lookup from the registered tables (read-before-write)
  always_comb begin
    f_idx       = pc_fetch[IDX_BITS+1:2];
    f_tag       = pc_fetch[XLEN-1:IDX_BITS+2];
    btb_hit     = btb_valid_q[f_idx] & (btb_tag_q[f_idx] == f_tag);
    pred_taken  = reset & fetch_valid & btb_hit & bht_q[f_idx][1];
    pred_target = pred_taken ? btb_target_q[f_idx] : pc_fetch + XLEN'(4);
  end

  // Execute-side resolution; an older mispredict kills the fetch redirect
  always_comb begin
    ex_idx              = ex_pc[IDX_BITS+1:2];
    ex_tag              = ex_pc[XLEN-1:IDX_BITS+2];
    resolve             = reset & ex_valid & ex_is_branch;
    mispredict          = (ex_actual_taken != ex_pred_taken) |
                          (ex_actual_taken & ex_pred_taken &
                           (ex_actual_target != ex_pred_target));
    branch_mispredicted = resolve & mispredict;
    redirect_pc         = '0;
    if (resolve) begin
      redirect_pc = ex_actual_taken ? ex_actual_target : ex_pc + XLEN'(4);
    end
    branch_taken        = pred_taken & ~branch_mispredicted;
  end

  // Table training and counter next-state
  always_comb begin
    bht_d              = bht_q;
    btb_valid_d        = btb_valid_q;
    btb_tag_d          = btb_tag_q;
    btb_target_d       = btb_target_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (resolve) begin
      if (ex_actual_taken) begin
        if (bht_q[ex_idx] != 2'b11) bht_d[ex_idx] = bht_q[ex_idx] + 2'd1;
        btb_valid_d[ex_idx]  = 1'b1;
        btb_tag_d[ex_idx]    = ex_tag;
        btb_target_d[ex_idx] = ex_actual_target;
      end else begin
        if (bht_q[ex_idx] != 2'b00) bht_d[ex_idx] = bht_q[ex_idx] - 2'd1;
      end
      if (branch_count_q != '1) branch_count_d = branch_count_q + CNT_W'(1);
      if (mispredict && (mispredict_count_q != '1)) begin
        mispredict_count_d = mispredict_count_q + CNT_W'(1);
      end
    end
  end

  // State that reset must clear: direction counters, valid bits, counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ENT; i++) bht_q[i] <= 2'b01;
      btb_valid_q        <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      bht_q              <= bht_d;
      btb_valid_q        <= btb_valid_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  // BTB payload; qualified by the valid bits so it needs no reset
  always_ff @(posedge clk) begin
    btb_tag_q    <= btb_tag_d;
    btb_target_q <= btb_target_d;
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_pred_unit.sv
// Directed bench for branch_pred_unit with hand-computed expectations.
module tb_branch_pred_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_fetch;
  logic        fetch_valid;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        branch_taken;
  logic        ex_valid;
  logic        ex_is_branch;
  logic [31:0] ex_pc;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        ex_actual_taken;
  logic [31:0] ex_actual_target;
  logic        branch_mispredicted;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int checks   = 0;
  int failures = 0;

  branch_pred_unit dut (
    .clk                 (clk),
    .reset               (reset),
    .pc_fetch            (pc_fetch),
    .fetch_valid         (fetch_valid),
    .pred_taken          (pred_taken),
    .pred_target         (pred_target),
    .branch_taken        (branch_taken),
    .ex_valid            (ex_valid),
    .ex_is_branch        (ex_is_branch),
    .ex_pc               (ex_pc),
    .ex_pred_taken       (ex_pred_taken),
    .ex_pred_target      (ex_pred_target),
    .ex_actual_taken     (ex_actual_taken),
    .ex_actual_target    (ex_actual_target),
    .branch_mispredicted (branch_mispredicted),
    .redirect_pc         (redirect_pc),
    .branch_count        (branch_count),
    .mispredict_count    (mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_drive(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt,
                          input logic at, input logic [31:0] atgt);
    ex_valid         = 1'b1;
    ex_is_branch     = 1'b1;
    ex_pc            = pc;
    ex_pred_taken    = pt;
    ex_pred_target   = ptgt;
    ex_actual_taken  = at;
    ex_actual_target = atgt;
  endtask

  task automatic ex_idle();
    ex_valid         = 1'b0;
    ex_is_branch     = 1'b0;
    ex_pc            = '0;
    ex_pred_taken    = 1'b0;
    ex_pred_target   = '0;
    ex_actual_taken  = 1'b0;
    ex_actual_target = '0;
  endtask

  initial begin
    reset       = 1'b0;
    pc_fetch    = 32'h100;
    fetch_valid = 1'b1;
    // Branch presented during reset must neither flag nor train
    ex_drive(32'h100, 1'b0, 32'h104, 1'b1, 32'h200);
    tick();
    tick();
    check("rst_pred_taken", 32'(pred_taken), 32'd0);
    check("rst_pred_target", pred_target, 32'h104);
    check("rst_branch_taken", 32'(branch_taken), 32'd0);
    check("rst_mispred", 32'(branch_mispredicted), 32'd0);
    check("rst_redirect", redirect_pc, 32'h0);
    check("rst_bcount", branch_count, 32'd0);
    check("rst_mcount", mispredict_count, 32'd0);
    ex_idle();
    #2 reset = 1'b1;

    // 1: cold lookup
    tick();
    check("t1_pred_taken", 32'(pred_taken), 32'd0);
    check("t1_pred_target", pred_target, 32'h104);
    check("t1_branch_taken", 32'(branch_taken), 32'd0);

    // 2: first taken resolution, lookup same cycle still sees old tables
    ex_drive(32'h100, 1'b0, 32'h104, 1'b1, 32'h200);
    #1;
    check("t2_mispred", 32'(branch_mispredicted), 32'd1);
    check("t2_redirect", redirect_pc, 32'h200);
    check("t2_rbw_pred", 32'(pred_taken), 32'd0);
    tick();
    ex_idle();
    #1;
    check("t2_pred_taken", 32'(pred_taken), 32'd1);
    check("t2_pred_target", pred_target, 32'h200);
    check("t2_branch_taken", 32'(branch_taken), 32'd1);
    check("t2_bcount", branch_count, 32'd1);
    check("t2_mcount", mispredict_count, 32'd1);

    // 3: three correct taken resolutions saturate the counter at 11
    for (int i = 0; i < 3; i++) begin
      ex_drive(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
      #1;
      check("t3_no_mispred", 32'(branch_mispredicted), 32'd0);
      check("t3_branch_taken", 32'(branch_taken), 32'd1);
      tick();
    end
    ex_idle();
    #1;
    check("t3_bcount", branch_count, 32'd4);
    check("t3_mcount", mispredict_count, 32'd1);

    // 3+4: not-taken mispredict while fetch predicts taken on the same index
    ex_drive(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    #1;
    check("t4_mispred", 32'(branch_mispredicted), 32'd1);
    check("t4_redirect", redirect_pc, 32'h104);
    check("t4_pred_taken", 32'(pred_taken), 32'd1);
    check("t4_branch_taken", 32'(branch_taken), 32'd0);
    tick();
    ex_idle();
    #1;
    // Counter 11 -> 10: still predicts taken, BTB kept the target
    check("t3_after_nt_pred", 32'(pred_taken), 32'd1);
    check("t3_after_nt_tgt", pred_target, 32'h200);
    check("t3_bcount2", branch_count, 32'd5);
    check("t3_mcount2", mispredict_count, 32'd2);

    // 5: right direction, wrong target
    ex_drive(32'h100, 1'b1, 32'h200, 1'b1, 32'h300);
    #1;
    check("t5_mispred", 32'(branch_mispredicted), 32'd1);
    check("t5_redirect", redirect_pc, 32'h300);
    tick();
    ex_idle();
    #1;
    check("t5_new_target", pred_target, 32'h300);
    check("t5_pred_taken", 32'(pred_taken), 32'd1);
    check("t5_mcount", mispredict_count, 32'd3);
    pc_fetch = 32'h1100;
    #1;
    check("t5_alias_pred", 32'(pred_taken), 32'd0);
    check("t5_alias_tgt", pred_target, 32'h1104);
    pc_fetch    = 32'h100;
    fetch_valid = 1'b0;
    #1;
    check("fv0_pred", 32'(pred_taken), 32'd0);
    check("fv0_tgt", pred_target, 32'h104);

    // Non-branch in EX: no flag, no redirect, no count
    fetch_valid  = 1'b1;
    ex_drive(32'h100, 1'b0, 32'h104, 1'b1, 32'h200);
    ex_is_branch = 1'b0;
    #1;
    check("nb_mispred", 32'(branch_mispredicted), 32'd0);
    check("nb_redirect", redirect_pc, 32'h0);
    tick();
    ex_idle();
    #1;
    check("nb_bcount", branch_count, 32'd6);

    // PC wrap: fetch and EX at the top of the address space
    pc_fetch = 32'hFFFF_FFFC;
    ex_drive(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    check("wrap_pred_tgt", pred_target, 32'h0);
    check("wrap_mispred", 32'(branch_mispredicted), 32'd0);
    check("wrap_redirect", redirect_pc, 32'h0);
    tick();
    ex_idle();
    pc_fetch = 32'h100;
    #1;
    check("wrap_bcount", branch_count, 32'd7);
    check("wrap_mcount", mispredict_count, 32'd3);
    check("pre_rst_pred", 32'(pred_taken), 32'd1);

    // 6: asynchronous reset mid-stream clears everything at once
    ex_drive(32'h100, 1'b0, 32'h104, 1'b1, 32'h300);
    #1 reset = 1'b0;
    #1;
    check("t6_pred_taken", 32'(pred_taken), 32'd0);
    check("t6_branch_taken", 32'(branch_taken), 32'd0);
    check("t6_pred_target", pred_target, 32'h104);
    check("t6_mispred", 32'(branch_mispredicted), 32'd0);
    check("t6_redirect", redirect_pc, 32'h0);
    check("t6_bcount", branch_count, 32'd0);
    check("t6_mcount", mispredict_count, 32'd0);
    ex_idle();
    tick();
    #2 reset = 1'b1;
    tick();
    check("t6_post_pred", 32'(pred_taken), 32'd0);
    check("t6_post_tgt", pred_target, 32'h104);
    check("t6_post_bcount", branch_count, 32'd0);
    check("t6_post_mcount", mispredict_count, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_pred_unit.md
Name: branch_pred_unit

Overview:
- Branch prediction and resolution unit. It produces the branch_taken and branch_mispredicted inputs consumed by the pipeline flush controller.
- Fetch side: a 2-bit-counter BHT plus a direct-mapped BTB predict direction and target for pc_fetch.
- Execute side: compares the actual branch outcome with the prediction carried down the pipe, raises the mispredict redirect, and trains the tables.
- Also keeps saturating performance counters.

Parameters:
XLEN, 32, address/data width
IDX_BITS, 6, log2 of BHT/BTB entries (64 entries)
TAG_BITS, XLEN-IDX_BITS-2, BTB tag width, derived, do not override

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
pc_fetch  in  XLEN  PC in fetch stage
fetch_valid  in  1  fetch stage holds a valid PC
pred_taken  out  1  predicted taken for pc_fetch (combinational)
pred_target  out  XLEN  predicted target (BTB target if hit, else pc_fetch+4)
branch_taken  out  1  fetch-stage predicted-taken redirect; flushes fetch/decode
ex_valid  in  1  EX stage holds a valid instruction
ex_is_branch  in  1  EX instruction is a branch/jump
ex_pc  in  XLEN  PC of EX instruction
ex_pred_taken  in  1  prediction carried with instruction
ex_pred_target  in  XLEN  predicted target carried with instruction
ex_actual_taken  in  1  resolved direction
ex_actual_target  in  XLEN  resolved target
branch_mispredicted  out  1  EX-stage mispredict; flushes fetch/decode and decode/execute
redirect_pc  out  XLEN  correct next PC when branch_mispredicted=1
branch_count  out  32  resolved branches, saturating
mispredict_count  out  32  mispredicts, saturating

Behaviour:
- Index = pc[IDX_BITS+1:2]. Tag = pc[XLEN-1:IDX_BITS+2].
- Reset (reset=0, asynchronous):
  - all BHT counters := 2'b01 (weakly not-taken)
  - all BTB valid bits := 0
  - branch_count and mispredict_count := 0
  - branch_taken, branch_mispredicted, pred_taken := 0
  - pred_target := pc_fetch+4
  - redirect_pc := 0
- Reset mid-operation discards all training. No update is written in the cycle reset deasserts unless clk rises with reset=1.
- Lookup (combinational from registered tables):
  - btb_hit = valid[idx] & tag match.
  - pred_taken = fetch_valid & btb_hit & bht[idx][1].
  - pred_target = pred_taken ? btb_target[idx] : pc_fetch+4.
- Resolve (combinational, only when ex_valid & ex_is_branch, else 0):
  - mispredict = (ex_actual_taken != ex_pred_taken) | (ex_actual_taken & ex_pred_taken & ex_actual_target != ex_pred_target).
  - branch_mispredicted = mispredict.
  - redirect_pc = ex_actual_taken ? ex_actual_target : ex_pc+4.
- branch_taken = pred_taken & ~branch_mispredicted. Mispredict has priority because an older instruction kills the fetch prediction.
- Update (posedge clk, when ex_valid & ex_is_branch):
  - BHT[ex idx]: taken → increment, saturating at 2'b11; not taken → decrement, saturating at 2'b00.
  - If ex_actual_taken: BTB[ex idx] := {valid=1, tag(ex_pc), ex_actual_target}, replacing any aliasing entry.
  - Not-taken resolution leaves the BTB unchanged.
- Simultaneous lookup and update to the same index: the lookup sees the pre-update value (read-before-write). The new value is visible the next cycle.
- Counters:
  - branch_count += 1 per resolved branch.
  - mispredict_count += 1 per mispredict.
  - Both hold at 32'hFFFF_FFFF (no wrap).
- Latency: prediction 0 cycles, resolution 0 cycles, table/counter update 1 cycle.
- PC arithmetic is modulo 2^XLEN: pc+4 wraps from 0xFFFF_FFFC to 0.

Test Plan:
1. Reset, then lookup pc_fetch=0x100 with fetch_valid=1 → pred_taken=0, pred_target=0x104, branch_taken=0.
2. Resolve ex_pc=0x100, actual_taken=1, target=0x200, pred_taken=0 → branch_mispredicted=1, redirect_pc=0x200. Next cycle, lookup 0x100 → BHT=2'b10, pred_taken=1, pred_target=0x200, branch_taken=1.
3. Resolve 0x100 taken three more times, then not-taken once → counter saturates at 2'b11 then reaches 2'b10; pred_taken stays 1. Not-taken resolution gives branch_mispredicted=1, redirect_pc=0x104.
4. Same cycle: fetch pc_fetch=0x100 predicting taken, while EX mispredicts → branch_mispredicted=1, branch_taken=0.
5. Correct direction with wrong target (pred 0x200, actual 0x300) → branch_mispredicted=1, redirect_pc=0x300, BTB target becomes 0x300. Aliasing pc 0x1100 (same idx, different tag) → btb_hit=0, pred_taken=0.
6. Assert reset low mid-stream after training → all outputs zero/default immediately (asynchronous). Lookup 0x100 after release → pred_taken=0. Both counters read 0.
